// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared write-back types for the 5-stage RISC-V pipeline
package rv_pipe_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN = 32;
  typedef enum logic [1:0] {
    RES_ALU = 2'd0,
    RES_MEM = 2'd1,
    RES_PC4 = 2'd2
  } result_src_e;
  typedef struct packed {
    logic [XLEN-1:0]       data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } wb_bundle_t;
endpackage

// File: rtl/skid_fifo2.sv
// skid_fifo2: 2-entry valid/ready buffer; the head lives in its own register so out_* hold their last popped value
module skid_fifo2 #(
  parameter type T = rv_pipe_pkg::wb_bundle_t
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_bundle,
  output logic out_valid,
  input  logic out_ready,
  output T     out_bundle
);
  T           r_mem [2];
  T           r_head;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] r_count;
  logic       w_push;
  logic       w_pop;
  logic       w_load_in;
  logic       w_load_mem;
  assign in_ready   = r_count < 2'd2;
  assign out_valid  = r_count != 2'd0;
  assign out_bundle = r_head;
  assign w_push     = in_valid && in_ready;
  assign w_pop      = out_valid && out_ready;
  // head reloads from the input when the pushed entry becomes head, or from the second slot when full pops
  assign w_load_in  = w_push && (r_count == 2'd0 || (r_count == 2'd1 && w_pop));
  assign w_load_mem = w_pop && r_count == 2'd2;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_head   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_mem[r_wr_ptr] <= in_bundle;
      r_wr_ptr <= r_wr_ptr ^ w_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_head   <= w_load_in ? in_bundle : w_load_mem ? r_mem[~r_rd_ptr] : r_head;
    end
  a_count_max: assert property (@(posedge clk) disable iff (reset) r_count <= 2'd2);
  a_out_stable: assert property (@(posedge clk) disable iff (reset)
    out_valid && !out_ready |=> $stable(out_bundle));
endmodule

// File: rtl/result_mux_pipe.sv
// result_mux_pipe: registered N-to-1 write-back result select with skid buffer and sticky out-of-range select flag
module result_mux_pipe
  import rv_pipe_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int NUM_IN = 3,
  localparam int SEL_W  = $clog2(NUM_IN),
  parameter  int DEPTH  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic [REG_ADDR_W-1:0]   in_rd,
  input  logic                    in_regwrite,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [REG_ADDR_W-1:0]   out_rd,
  output logic                    out_regwrite,
  output logic                    sel_oob,
  input  logic                    sel_oob_clr
);
  localparam int NSLOT = 2 ** SEL_W;
  typedef struct packed {
    logic [WIDTH-1:0]      data;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } bundle_t;
  logic [WIDTH-1:0] w_src [NSLOT];
  logic [NSLOT-1:0] w_oob_map;
  bundle_t          w_in;
  bundle_t          w_out;
  logic             w_push;
  logic             w_oob;
  logic             r_sel_oob;
  if (DEPTH != 2) begin : g_depth_chk
    $error("result_mux_pipe: DEPTH must be 2");
  end
  if (NUM_IN < 2 || NUM_IN > 16) begin : g_num_chk
    $error("result_mux_pipe: NUM_IN must be in 2..16");
  end
  // unused select codes alias the last source, which gives saturation without a comparator on the data path
  for (genvar i = 0; i < NSLOT; i++) begin : g_src
    localparam int SRC = (i < NUM_IN) ? i : NUM_IN - 1;
    assign w_src[i]     = in_data[SRC*WIDTH +: WIDTH];
    assign w_oob_map[i] = i >= NUM_IN;
  end
  assign w_in   = {w_src[in_sel], in_rd, in_regwrite};
  assign w_oob  = w_oob_map[in_sel];
  assign w_push = in_valid && in_ready;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_sel_oob <= 1'b0;
    else r_sel_oob <= (w_push && w_oob) || (r_sel_oob && !sel_oob_clr);
  skid_fifo2 #(.T(bundle_t)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bundle (w_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bundle(w_out)
  );
  assign out_data     = w_out.data;
  assign out_rd       = w_out.rd;
  assign out_regwrite = w_out.regwrite;
  assign sel_oob      = r_sel_oob;
endmodule

// File: tb/tb_result_mux_pipe.sv
// tb_result_mux_pipe: scoreboard bench for result_mux_pipe at NUM_IN=3/8/2
module tb_result_mux_pipe;
  typedef struct packed {
    logic [63:0] d;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t ea, eb, ec;
  logic        a_flush, a_in_valid, a_in_ready, a_in_rw, a_out_valid, a_out_ready, a_out_rw, a_sel_oob, a_clr;
  logic [95:0] a_in_data;
  logic [1:0]  a_in_sel;
  logic [4:0]  a_in_rd, a_out_rd;
  logic [31:0] a_out_data;
  logic         b_flush, b_in_valid, b_in_ready, b_in_rw, b_out_valid, b_out_ready, b_out_rw, b_sel_oob, b_clr;
  logic [511:0] b_in_data;
  logic [2:0]   b_in_sel;
  logic [4:0]   b_in_rd, b_out_rd;
  logic [63:0]  b_out_data;
  logic        c_flush, c_in_valid, c_in_ready, c_in_rw, c_out_valid, c_out_ready, c_out_rw, c_sel_oob, c_clr;
  logic [63:0] c_in_data;
  logic [0:0]  c_in_sel;
  logic [4:0]  c_in_rd, c_out_rd;
  logic [31:0] c_out_data;
  logic [63:0] b_tab [8] = '{64'h1000_0000_0000_0001, 64'h2000_0000_0000_0002, 64'h3000_0000_0000_0003,
                             64'h4000_0000_0000_0004, 64'h5000_0000_0000_0005, 64'h6000_0000_0000_0006,
                             64'h7000_0000_0000_0007, 64'hFEDC_BA98_7654_3210};
  logic [31:0] c_tab [2] = '{32'hA5A5_0000, 32'h5A5A_FFFF};
  result_mux_pipe #(.WIDTH(32), .NUM_IN(3)) u_a (
    .clk(clk), .reset(reset), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_sel(a_in_sel), .in_rd(a_in_rd), .in_regwrite(a_in_rw),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_rd(a_out_rd),
    .out_regwrite(a_out_rw), .sel_oob(a_sel_oob), .sel_oob_clr(a_clr));
  result_mux_pipe #(.WIDTH(64), .NUM_IN(8)) u_b (
    .clk(clk), .reset(reset), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_sel(b_in_sel), .in_rd(b_in_rd), .in_regwrite(b_in_rw),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_rd(b_out_rd),
    .out_regwrite(b_out_rw), .sel_oob(b_sel_oob), .sel_oob_clr(b_clr));
  result_mux_pipe #(.WIDTH(32), .NUM_IN(2)) u_c (
    .clk(clk), .reset(reset), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_sel(c_in_sel), .in_rd(c_in_rd), .in_regwrite(c_in_rw),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_rd(c_out_rd),
    .out_regwrite(c_out_rw), .sel_oob(c_sel_oob), .sel_oob_clr(c_clr));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask
  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask
  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s in_ready=0 required=1 within 50 cycles", name);
  endtask
  task automatic push_a(input logic [1:0] sel, input logic [4:0] rd, input logic rw, input logic [31:0] d);
    int n = 0;
    a_in_valid = 1'b1; a_in_sel = sel; a_in_rd = rd; a_in_rw = rw;
    qa.push_back('{d: {32'h0, d}, rd: rd, rw: rw});
    while (!a_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout("a_push");
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask
  task automatic push_b(input logic [2:0] sel, input logic [4:0] rd, input logic [63:0] d);
    int n = 0;
    b_in_valid = 1'b1; b_in_sel = sel; b_in_rd = rd; b_in_rw = rd[0];
    qb.push_back('{d: d, rd: rd, rw: rd[0]});
    while (!b_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout("b_push");
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask
  task automatic push_c(input logic [0:0] sel, input logic [4:0] rd, input logic [31:0] d);
    int n = 0;
    c_in_valid = 1'b1; c_in_sel = sel; c_in_rd = rd; c_in_rw = rd[0];
    qc.push_back('{d: {32'h0, d}, rd: rd, rw: rd[0]});
    while (!c_in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) timeout("c_push");
    @(posedge clk); #1;
    c_in_valid = 1'b0;
  endtask
  logic        a_stall = 1'b0;
  logic [37:0] a_prev = '0;
  always @(negedge clk) begin
    if (a_out_valid && a_stall) chk("a_stable", 64'({a_out_data, a_out_rd, a_out_rw}), 64'(a_prev));
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) begin
        checks++; failures++;
        $display("FAIL a_unexpected_pop data=0x%0h required=none", a_out_data);
      end else begin
        ea = qa.pop_front();
        chk("a_data", 64'(a_out_data), ea.d);
        chk("a_rd", 64'(a_out_rd), 64'(ea.rd));
        chk1("a_regwrite", a_out_rw, ea.rw);
      end
    end
    a_stall <= a_out_valid && !a_out_ready;
    a_prev  <= {a_out_data, a_out_rd, a_out_rw};
  end
  always @(negedge clk)
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) begin
        checks++; failures++;
        $display("FAIL b_unexpected_pop data=0x%0h required=none", b_out_data);
      end else begin
        eb = qb.pop_front();
        chk("b_data", b_out_data, eb.d);
        chk("b_rd", 64'(b_out_rd), 64'(eb.rd));
        chk1("b_regwrite", b_out_rw, eb.rw);
      end
    end
  always @(negedge clk)
    if (c_out_valid && c_out_ready) begin
      if (qc.size() == 0) begin
        checks++; failures++;
        $display("FAIL c_unexpected_pop data=0x%0h required=none", c_out_data);
      end else begin
        ec = qc.pop_front();
        chk("c_data", 64'(c_out_data), ec.d);
        chk("c_rd", 64'(c_out_rd), 64'(ec.rd));
        chk1("c_regwrite", c_out_rw, ec.rw);
      end
    end
  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    a_flush = 0; a_in_valid = 0; a_in_data = {32'h33, 32'h22, 32'h11}; a_in_sel = 0; a_in_rd = 0;
    a_in_rw = 0; a_out_ready = 1; a_clr = 0;
    b_flush = 0; b_in_valid = 0; b_in_sel = 0; b_in_rd = 0; b_in_rw = 0; b_out_ready = 1; b_clr = 0;
    c_flush = 0; c_in_valid = 0; c_in_sel = 0; c_in_rd = 0; c_in_rw = 0; c_out_ready = 1; c_clr = 0;
    for (int k = 0; k < 8; k++) b_in_data[k*64 +: 64] = b_tab[k];
    c_in_data = {c_tab[1], c_tab[0]};
    #12;
    chk1("rst_out_valid", a_out_valid, 1'b0);
    chk1("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_out_data", 64'(a_out_data), 64'h0);
    chk("rst_out_rd", 64'(a_out_rd), 64'h0);
    chk1("rst_out_regwrite", a_out_rw, 1'b0);
    chk1("rst_sel_oob", a_sel_oob, 1'b0);
    @(posedge clk); #1;
    reset = 0;
    push_a(2'd0, 5'd1, 1'b1, 32'h11);
    chk1("a_latency_valid", a_out_valid, 1'b1);
    push_a(2'd1, 5'd2, 1'b0, 32'h22);
    push_a(2'd2, 5'd3, 1'b1, 32'h33);
    repeat (3) @(posedge clk); #1;
    chk1("a_stream_drained", a_out_valid, 1'b0);
    a_in_data = {32'hDEADBEEF, 32'h22, 32'h11};
    push_a(2'd3, 5'd4, 1'b1, 32'hDEADBEEF);
    chk1("a_oob_set", a_sel_oob, 1'b1);
    a_clr = 1; @(posedge clk); #1; a_clr = 0;
    chk1("a_oob_clr", a_sel_oob, 1'b0);
    a_clr = 1;
    push_a(2'd3, 5'd5, 1'b0, 32'hDEADBEEF);
    a_clr = 0;
    chk1("a_oob_set_wins", a_sel_oob, 1'b1);
    a_clr = 1; @(posedge clk); #1; a_clr = 0;
    push_a(2'd2, 5'd6, 1'b1, 32'hDEADBEEF);
    chk1("a_oob_legal_sel", a_sel_oob, 1'b0);
    repeat (2) @(posedge clk); #1;
    a_in_data = {32'h33, 32'h22, 32'h11};
    a_out_ready = 0;
    push_a(2'd0, 5'd7, 1'b1, 32'h11);
    push_a(2'd1, 5'd8, 1'b0, 32'h22);
    chk1("a_full_in_ready", a_in_ready, 1'b0);
    a_in_valid = 1; a_in_sel = 2'd2; a_in_rd = 5'd9; a_in_rw = 1;
    qa.push_back('{d: 64'h33, rd: 5'd9, rw: 1'b1});
    repeat (3) begin @(posedge clk); #1; chk1("a_hold_in_ready", a_in_ready, 1'b0); end
    a_out_ready = 1;
    @(posedge clk); #1;
    chk1("a_slot_free", a_in_ready, 1'b1);
    @(posedge clk); #1;
    a_in_valid = 0;
    repeat (3) @(posedge clk); #1;
    chk1("a_bp_drained", a_out_valid, 1'b0);
    a_out_ready = 0;
    push_a(2'd0, 5'd10, 1'b1, 32'h11);
    push_a(2'd1, 5'd11, 1'b1, 32'h22);
    a_in_valid = 1; a_in_sel = 2'd2; a_in_rd = 5'd12; a_in_rw = 1; a_flush = 1;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0; qa.delete();
    chk1("a_flush_full_valid", a_out_valid, 1'b0);
    chk1("a_flush_full_ready", a_in_ready, 1'b1);
    push_a(2'd0, 5'd13, 1'b1, 32'h11);
    a_out_ready = 1; a_in_valid = 1; a_in_sel = 2'd2; a_in_rd = 5'd14; a_in_rw = 1; a_flush = 1;
    @(posedge clk); #1;
    a_flush = 0; a_in_valid = 0; qa.delete();
    chk1("a_flush_pushpop_valid", a_out_valid, 1'b0);
    repeat (3) @(posedge clk); #1;
    chk1("a_flush_nothing_left", a_out_valid, 1'b0);
    a_out_ready = 0;
    push_a(2'd0, 5'd15, 1'b1, 32'h11);
    push_a(2'd1, 5'd16, 1'b1, 32'h22);
    #3 reset = 1;
    #1;
    chk1("a_arst_out_valid", a_out_valid, 1'b0);
    chk("a_arst_out_data", 64'(a_out_data), 64'h0);
    chk1("a_arst_in_ready", a_in_ready, 1'b1);
    chk("a_arst_out_rd", 64'(a_out_rd), 64'h0);
    qa.delete();
    @(posedge clk); #3 reset = 0;
    @(posedge clk); #1;
    a_out_ready = 1;
    push_a(2'd2, 5'd17, 1'b1, 32'h33);
    chk1("a_post_rst_latency", a_out_valid, 1'b1);
    for (int k = 0; k < 8; k++) push_b(3'(k), 5'(k + 1), b_tab[k]);
    chk1("b_no_oob", b_sel_oob, 1'b0);
    push_c(1'b0, 5'd20, c_tab[0]);
    chk1("c_no_oob_0", c_sel_oob, 1'b0);
    push_c(1'b1, 5'd21, c_tab[1]);
    chk1("c_no_oob_1", c_sel_oob, 1'b0);
    push_c(1'b1, 5'd22, c_tab[1]);
    repeat (4) @(posedge clk); #1;
    chk("qa_empty", 64'(qa.size()), 64'h0);
    chk("qb_empty", 64'(qb.size()), 64'h0);
    chk("qc_empty", 64'(qc.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
